bp_mem_arbiter: RTL and testbench

- Sequences and shares the single-port 8-bit latch RAM (perceptron weight store) between two requesters:
  - the predictor core;
  - a host/debug port used for weight dump/load.
- Owns the post-reset clear sweep and enforces the RAM write timing: address/data stable, write enable high 2 cycles, then 1 low recovery cycle.
- Sits between the predictor FSM and the latch RAM macro.

---
 rtl/bp_mem_pkg.sv | 26 ++
 rtl/bp_mem_arbiter_if.sv | 15 +
 rtl/bp_mem_pick.sv | 29 ++
 rtl/bp_mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_bp_mem_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/bp_mem_pkg.sv
// Shared types and constants for the perceptron weight-store arbiter.
package bp_mem_pkg;

    localparam int unsigned ADDR_MAX_W  = 7;
    localparam int unsigned WR_HOLD     = 2;
    localparam int unsigned WR_REC_CYC  = 1;

    typedef enum logic [3:0] {
        INIT_A, INIT_W1, INIT_W2, INIT_REC,
        IDLE, RD_ADDR, RD_DATA,
        WR_A, WR_W1, WR_W2, WR_REC
    } state_e;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

    // Command payload of the selected requester, address zero-extended to the max width
    typedef struct packed {
        logic                  we;
        logic [ADDR_MAX_W-1:0] addr;
        logic [7:0]            wdata;
    } cmd_t;

endpackage

// File: rtl/bp_mem_arbiter_if.sv
// Requester-side request/grant/done bundle for one port of the weight-store arbiter.
interface bp_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 7
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
    logic              gnt;
    logic              done;
    logic [7:0]        rdata;

    modport master (output req, we, addr, wdata, input gnt, done, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, done, rdata);
endinterface

// File: rtl/bp_mem_pick.sv
// Combinational winner pick between core and host requests.
// Round-robin on conflict when BP_MEM_ROUND_ROBIN_EN is defined, else fixed core priority.
module bp_mem_pick
    import bp_mem_pkg::*;
(
    input  logic   core_req,
    input  logic   host_req,
    input  owner_e last_owner,
    output logic   any_c,
    output owner_e win_c
);

    always_comb begin
        any_c = core_req | host_req;
        win_c = core_req ? OWN_CORE : OWN_HOST;
`ifdef BP_MEM_ROUND_ROBIN_EN
        // On conflict the port that did not win last time goes first
        if (core_req && host_req) begin
            win_c = (last_owner == OWN_HOST) ? OWN_CORE : OWN_HOST;
        end
`endif
    end

`ifndef BP_MEM_ROUND_ROBIN_EN
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/bp_mem_arbiter.sv
// Shares the single-port latch weight RAM between predictor core and host port, owns the clear sweep.
// Optional round-robin conflict resolution via BP_MEM_ROUND_ROBIN_EN (see bp_mem_pick).
module bp_mem_arbiter
    import bp_mem_pkg::*;
#(
    parameter int unsigned STORAGE_B  = 96,
    parameter int unsigned ADDR_W     = $clog2(STORAGE_B),
    parameter logic [7:0]  INIT_VALUE = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    bp_mem_arbiter_if.slave   core_if,
    bp_mem_arbiter_if.slave   host_if,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              init_done
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    owner_e            owner_q, owner_d;
    logic              oor_q, oor_d;
    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [7:0]        mem_wdata_d;
    logic              core_done_d, host_done_d, init_done_d;
    logic [7:0]        core_rdata_d, host_rdata_d;

    logic              any_c, gnt_c, sel_oor_c;
    owner_e            win_c;
    cmd_t              sel_cmd_c;

    bp_mem_pick u_pick (
        .core_req   (core_if.req),
        .host_req   (host_if.req),
        .last_owner (owner_q),
        .any_c      (any_c),
        .win_c      (win_c)
    );

    // Selected requester's command and grant qualification
    always_comb begin
        if (win_c == OWN_CORE) begin
            sel_cmd_c.we    = core_if.we;
            sel_cmd_c.addr  = ADDR_MAX_W'(core_if.addr);
            sel_cmd_c.wdata = core_if.wdata;
        end else begin
            sel_cmd_c.we    = host_if.we;
            sel_cmd_c.addr  = ADDR_MAX_W'(host_if.addr);
            sel_cmd_c.wdata = host_if.wdata;
        end
        sel_oor_c = 32'(sel_cmd_c.addr) >= STORAGE_B;
        gnt_c     = (state_q == IDLE) && any_c;
    end

    assign core_if.gnt = gnt_c && (win_c == OWN_CORE);
    assign host_if.gnt = gnt_c && (win_c == OWN_HOST);

    // Next state and next values of every registered output
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        owner_d      = owner_q;
        oor_d        = oor_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        core_done_d  = 1'b0;
        host_done_d  = 1'b0;
        core_rdata_d = core_if.rdata;
        host_rdata_d = host_if.rdata;
        init_done_d  = init_done;

        case (state_q)
            INIT_A: begin
                state_d  = INIT_W1;
                mem_we_d = 1'b1;
            end
            INIT_W1: begin
                state_d  = INIT_W2;
                mem_we_d = 1'b1;
            end
            INIT_W2: state_d = INIT_REC;
            INIT_REC: begin
                if (idx_q == ADDR_W'(STORAGE_B - 1)) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end else begin
                    state_d     = INIT_A;
                    idx_d       = idx_q + 1'b1;
                    mem_addr_d  = idx_q + 1'b1;
                    mem_wdata_d = INIT_VALUE;
                end
            end
            IDLE: begin
                if (gnt_c) begin
                    owner_d    = win_c;
                    oor_d      = sel_oor_c;
                    mem_addr_d = ADDR_W'(sel_cmd_c.addr);
                    if (sel_cmd_c.we) begin
                        state_d     = WR_A;
                        mem_wdata_d = sel_cmd_c.wdata;
                    end else begin
                        state_d = RD_ADDR;
                    end
                end
            end
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: begin
                state_d = IDLE;
                if (owner_q == OWN_CORE) begin
                    core_done_d  = 1'b1;
                    core_rdata_d = oor_q ? 8'h00 : mem_rdata;
                end else begin
                    host_done_d  = 1'b1;
                    host_rdata_d = oor_q ? 8'h00 : mem_rdata;
                end
            end
            // Out-of-range writes walk the same timing with the enable suppressed
            WR_A: begin
                state_d  = WR_W1;
                mem_we_d = !oor_q;
            end
            WR_W1: begin
                state_d  = WR_W2;
                mem_we_d = !oor_q;
            end
            WR_W2: state_d = WR_REC;
            WR_REC: begin
                state_d     = IDLE;
                core_done_d = (owner_q == OWN_CORE);
                host_done_d = (owner_q == OWN_HOST);
            end
            default: state_d = INIT_A;
        endcase
    end

    // State and registered outputs; reset restarts the clear sweep
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= INIT_A;
            idx_q         <= '0;
            owner_q       <= OWN_HOST;
            oor_q         <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= INIT_VALUE;
            core_if.done  <= 1'b0;
            host_if.done  <= 1'b0;
            core_if.rdata <= 8'h00;
            host_if.rdata <= 8'h00;
            init_done     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            owner_q       <= owner_d;
            oor_q         <= oor_d;
            mem_we        <= mem_we_d;
            mem_addr      <= mem_addr_d;
            mem_wdata     <= mem_wdata_d;
            core_if.done  <= core_done_d;
            host_if.done  <= host_done_d;
            core_if.rdata <= core_rdata_d;
            host_if.rdata <= host_rdata_d;
            init_done     <= init_done_d;
        end
    end

endmodule

// File: tb/tb_bp_mem_arbiter.sv
// Directed bench for bp_mem_arbiter with a behavioural latch-RAM model.
module tb_bp_mem_arbiter;
    import bp_mem_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       mem_we;
    logic [6:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       init_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ram [0:127] = '{default: 8'h5A};

    bp_mem_arbiter_if #(.ADDR_W(7)) core_bus ();
    bp_mem_arbiter_if #(.ADDR_W(7)) host_bus ();

    bp_mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .core_if   (core_bus),
        .host_if   (host_bus),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model; out-of-range reads return a marker the arbiter must hide
    always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;
    assign mem_rdata = (mem_addr < 7'd96) ? ram[mem_addr] : 8'hEE;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts at cycle 0 after reset release; ends in the done cycle of the read granted at 384
    task automatic sweep_check(input string tag);
        logic [31:0] exp;
        for (int c = 0; c < 384; c++) begin
            if (c == 10) begin
                core_bus.req  = 1'b1;
                core_bus.we   = 1'b0;
                core_bus.addr = 7'd0;
            end
            #1;
            exp = {13'd0, ((c % 4 == 1) || (c % 4 == 2)), 7'(c / 4), 8'h00, 3'b000};
            check_eq(tag, {13'd0, mem_we, mem_addr, mem_wdata, init_done,
                           core_bus.gnt | host_bus.gnt, core_bus.done | host_bus.done}, exp);
            @(posedge clk);
            #1;
        end
        #1;
        check_eq({tag, "_init_done"}, init_done, 1);
        check_eq({tag, "_first_gnt"}, core_bus.gnt, 1);
        tick();
        core_bus.req = 1'b0;
        tick();
        tick();
        check_eq({tag, "_rd0_done"}, core_bus.done, 1);
        check_eq({tag, "_rd0_data"}, core_bus.rdata, 8'h00);
    endtask

    // One transaction on one port: checks grant, done latency, write-enable cycles and read data
    task automatic run_txn(input string tag, input bit host, input bit we, input logic [6:0] addr,
                           input logic [7:0] wdata, input int exp_lat, input int exp_we,
                           input logic [7:0] exp_rdata);
        int  waited = 0;
        int  lat    = 1;
        int  we_cnt = 0;
        bit  seen   = 0;
        if (host) begin
            host_bus.req = 1'b1; host_bus.we = we; host_bus.addr = addr; host_bus.wdata = wdata;
        end else begin
            core_bus.req = 1'b1; core_bus.we = we; core_bus.addr = addr; core_bus.wdata = wdata;
        end
        #1;
        while (!(host ? host_bus.gnt : core_bus.gnt) && waited < 20) begin
            @(posedge clk);
            #2;
            waited++;
        end
        check_eq({tag, "_gnt"}, host ? host_bus.gnt : core_bus.gnt, 1);
        tick();
        if (host) host_bus.req = 1'b0; else core_bus.req = 1'b0;
        while (!seen && lat < 20) begin
            we_cnt += int'(mem_we);
            if (host ? host_bus.done : core_bus.done) begin
                seen = 1;
            end else begin
                tick();
                lat++;
            end
        end
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_we_cycles"}, we_cnt, exp_we);
        check_eq({tag, "_other_done"}, host ? core_bus.done : host_bus.done, 0);
        if (!we) check_eq({tag, "_rdata"}, host ? host_bus.rdata : core_bus.rdata, exp_rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_host [4];
        int waited;
        rst_n = 1'b0;
        core_bus.req = 1'b0; core_bus.we = 1'b0; core_bus.addr = '0; core_bus.wdata = '0;
        host_bus.req = 1'b0; host_bus.we = 1'b0; host_bus.addr = '0; host_bus.wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        check_eq("rst_init_done", init_done, 0);
        check_eq("rst_dones", {core_bus.done, host_bus.done}, 0);
        check_eq("rst_rdatas", {core_bus.rdata, host_bus.rdata}, 0);
        rst_n = 1'b1;

        sweep_check("sweep1");
        run_txn("clr95", 0, 0, 7'd95, 8'h00, 3, 0, 8'h00);

        run_txn("core_wr5", 0, 1, 7'd5, 8'h7F, 5, WR_HOLD, 8'h00);
        check_eq("core_wr5_addr_hold", mem_addr, 5);
        run_txn("core_rd5", 0, 0, 7'd5, 8'h00, 3, 0, 8'h7F);
        run_txn("host_wr4", 1, 1, 7'd4, 8'h44, 5, WR_HOLD, 8'h00);

        // Simultaneous reads: core first, host granted in the core done cycle
        core_bus.req = 1'b1; core_bus.we = 1'b0; core_bus.addr = 7'd3;
        host_bus.req = 1'b1; host_bus.we = 1'b0; host_bus.addr = 7'd4;
        #1;
        check_eq("conf_gnt", {core_bus.gnt, host_bus.gnt}, 2'b10);
        tick();
        core_bus.req = 1'b0;
        tick();
        tick();
        check_eq("conf_core_done", {core_bus.done, host_bus.done}, 2'b10);
        check_eq("conf_core_rdata", core_bus.rdata, 8'h00);
        check_eq("conf_host_gnt", host_bus.gnt, 1);
        tick();
        host_bus.req = 1'b0;
        tick();
        tick();
        check_eq("conf_host_done", {core_bus.done, host_bus.done}, 2'b01);
        check_eq("conf_host_rdata", host_bus.rdata, 8'h44);

        run_txn("host_wr100", 1, 1, 7'd100, 8'hAA, 5, 0, 8'h00);
        run_txn("host_rd100", 1, 0, 7'd100, 8'h00, 3, 0, 8'h00);

        // Both ports requesting continuously
`ifdef BP_MEM_ROUND_ROBIN_EN
        exp_host = '{0, 1, 0, 1};
`else
        exp_host = '{0, 0, 0, 0};
`endif
        core_bus.req = 1'b1; core_bus.we = 1'b0; core_bus.addr = 7'd5;
        host_bus.req = 1'b1; host_bus.we = 1'b0; host_bus.addr = 7'd4;
        for (int k = 0; k < 4; k++) begin
            waited = 0;
            #1;
            while (!(core_bus.gnt || host_bus.gnt) && waited < 10) begin
                tick();
                #1;
                waited++;
            end
            check_eq($sformatf("arb%0d_any", k), core_bus.gnt | host_bus.gnt, 1);
            check_eq($sformatf("arb%0d_host", k), host_bus.gnt, exp_host[k]);
            tick();
        end
        core_bus.req = 1'b0;
        host_bus.req = 1'b0;
        repeat (4) tick();

        // Reset in WR_W1 aborts the write and restarts the sweep
        core_bus.req = 1'b1; core_bus.we = 1'b1; core_bus.addr = 7'd6; core_bus.wdata = 8'h11;
        #1;
        check_eq("abort_gnt", core_bus.gnt, 1);
        tick();
        core_bus.req = 1'b0;
        check_eq("abort_wr_a_we", mem_we, 0);
        tick();
        check_eq("abort_wr_w1_we", mem_we, 1);
        rst_n = 1'b0;
        tick();
        check_eq("abort_mem_we", mem_we, 0);
        check_eq("abort_mem_addr", mem_addr, 0);
        check_eq("abort_init_done", init_done, 0);
        check_eq("abort_dones", {core_bus.done, host_bus.done}, 0);
        check_eq("abort_rdatas", {core_bus.rdata, host_bus.rdata}, 0);
        rst_n = 1'b1;
        sweep_check("sweep2");
        run_txn("clr6", 0, 0, 7'd6, 8'h00, 3, 0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
